// File: rtl/fc_score_collector.sv
// fc_score_collector: rounds, shifts and saturates serial accumulator results (acc_in/valid_in/start_in) into a parallel score frame (data_out, valid_out pulse, busy, frame_err pulse)
module fc_score_collector #(
  parameter int ACC_W = 24,
  parameter int OUT_W = 12,
  parameter int SHIFT = 8,
  parameter int NUM_CLASSES = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    valid_in,
  input  logic                    start_in,
  input  logic signed [ACC_W-1:0] acc_in,
  output logic signed [OUT_W-1:0] data_out [NUM_CLASSES],
  output logic                    valid_out,
  output logic                    busy,
  output logic                    frame_err
);
  localparam int CW = $clog2(NUM_CLASSES);
  localparam logic signed [ACC_W:0] RND = (ACC_W+1)'((2**SHIFT)/2);
  localparam logic signed [ACC_W:0] SMAX = (ACC_W+1)'(2**(OUT_W-1)-1);
  localparam logic signed [ACC_W:0] SMIN = ~SMAX;
  typedef enum logic {IDLE, COLLECT} state_t;
  state_t state, state_d;
  logic [CW-1:0] cnt, cnt_d, wa;
  logic wr, commit, err;
  logic signed [ACC_W:0] ext, sh;
  logic signed [OUT_W-1:0] scaled;
  logic signed [OUT_W-1:0] shadow [NUM_CLASSES-1];
  assign ext = {acc_in[ACC_W-1], acc_in} + RND;
  assign sh = ext >>> SHIFT;
  assign scaled = sh > SMAX ? OUT_W'(SMAX) : sh < SMIN ? OUT_W'(SMIN) : OUT_W'(sh);
  assign wa = start_in ? '0 : cnt;
  assign busy = state == COLLECT;
  always_comb begin
    state_d = state;
    cnt_d = cnt;
    wr = 1'b0;
    commit = 1'b0;
    err = 1'b0;
    if (valid_in) begin
      if (start_in) begin
        wr = 1'b1;
        cnt_d = CW'(1);
        err = state == COLLECT;
        state_d = COLLECT;
      end else if (state == IDLE) begin
        err = 1'b1;
      end else if (cnt == CW'(NUM_CLASSES-1)) begin
        commit = 1'b1;
        cnt_d = '0;
        state_d = IDLE;
      end else begin
        wr = 1'b1;
        cnt_d = cnt + 1'b1;
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      valid_out <= 1'b0;
      frame_err <= 1'b0;
      for (int i = 0; i < NUM_CLASSES-1; i++) shadow[i] <= '0;
      for (int i = 0; i < NUM_CLASSES; i++) data_out[i] <= '0;
    end else begin
      state <= state_d;
      cnt <= cnt_d;
      valid_out <= commit;
      frame_err <= err;
      if (wr) shadow[wa] <= scaled;
      if (commit) begin
        for (int i = 0; i < NUM_CLASSES-1; i++) data_out[i] <= shadow[i];
        data_out[NUM_CLASSES-1] <= scaled;
      end
    end
  end
endmodule

// File: doc/fc_score_collector.md
Name: fc_score_collector

Overview:
- Streaming output stage of the final fully-connected layer; sits directly upstream of the class-decision comparator.
- Accepts one wide signed accumulator result per cycle, serially, one per class.
- Rescales and rounds each result, then saturates it to the comparator's 12-bit signed score width.
- Presents all NUM_CLASSES scores in parallel together with a single-cycle valid pulse once a complete frame has been collected.

Parameters:
- ACC_W, 24, width of the signed accumulator input.
- OUT_W, 12, width of each signed output score. Fixed to match the comparator.
- SHIFT, 8, arithmetic right shift applied to each accumulator value (0 to ACC_W-2).
- NUM_CLASSES, 10, number of scores per frame. Fixed to match the comparator.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- valid_in  input  1  acc_in (and start_in) are valid this cycle.
- start_in  input  1  qualifies valid_in; marks the class-0 element of a frame.
- acc_in  input  ACC_W  signed accumulator value for the current class.
- data_out  output  NUM_CLASSES x OUT_W  signed score array, index 0..NUM_CLASSES-1.
- valid_out  output  1  one-cycle pulse; data_out holds a new complete frame.
- busy  output  1  high while a frame is partially collected.
- frame_err  output  1  one-cycle pulse on a protocol violation.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - data_out all 0, valid_out 0, busy 0, frame_err 0.
  - Slot counter 0, state IDLE, shadow buffer cleared.
  - Reset mid-frame discards the partial frame; no valid_out follows.
- Scaling, per accepted element, combinational ahead of the shadow write:
  - If SHIFT>0, add 2^(SHIFT-1) (round half up), using ACC_W+1 bits so the add cannot overflow.
  - Arithmetic right shift by SHIFT.
  - Saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1], i.e. [-2048, 2047].
- FSM states: IDLE, COLLECT.
  - IDLE, valid_in & start_in: write scaled value to shadow[0]; cnt=1; go to COLLECT.
  - IDLE, valid_in & !start_in: element dropped; frame_err pulses the next cycle; stay in IDLE.
  - COLLECT, valid_in & !start_in, cnt<NUM_CLASSES-1: write shadow[cnt]; cnt++.
  - COLLECT, valid_in & !start_in, cnt==NUM_CLASSES-1: commit.
    - data_out <= shadow[0..NUM_CLASSES-2] plus the current scaled value, in the same edge.
    - valid_out=1 in the following cycle.
    - cnt=0; go to IDLE.
  - COLLECT, valid_in & start_in: restart. Discard the partial frame, write shadow[0], cnt=1, frame_err pulses, stay in COLLECT.
  - COLLECT, !valid_in: hold. Gaps of any length are allowed.
- Latency: data_out and valid_out update at the clock edge after the cycle in which the last element is presented (1 cycle).
- data_out changes only on commit. It is stable between valid_out pulses, including during partial and aborted frames.
- Back-to-back frames: start_in may arrive in the cycle immediately after the last element of the previous frame.
  - Throughput is one element per cycle with no bubbles.
- busy = (state==COLLECT), registered.
- valid_out and frame_err are never high for more than one consecutive cycle per event.
- No backpressure: the downstream stage always accepts.

Test Plan:
- Reset mid-frame:
  - Stimulus: assert rst after 5 elements, release, then send a full frame.
  - Required: no valid_out from the aborted frame; exactly one valid_out for the new frame; busy=0 right after reset.
- Rounding, SHIFT=8:
  - Stimulus: acc_in = 384, -384, 127, 128, -129, 0, 256, -256, 1, -1.
  - Required: data_out = {2, -1, 0, 1, -1, 0, 1, -1, 0, 0}; valid_out one cycle after the 10th element.
- Saturation:
  - Stimulus: acc_in = 1000000 and -1000000 in slots 3 and 7.
  - Required: data_out[3]=2047, data_out[7]=-2048.
- Protocol errors:
  - Stimulus: valid_in without start_in while IDLE.
  - Required: frame_err pulse, no state change.
  - Stimulus: start_in at element 6 of a frame.
  - Required: frame_err pulse; the frame restarts; valid_out occurs only after 10 more elements; data_out is unchanged in between.
- Back-to-back with gaps:
  - Stimulus: two frames with random valid_in gaps, the second start_in immediately after the first frame's last element.
  - Required: two valid_out pulses, each with the correct frame contents.
  - Required: fed into the comparator, the decision equals the argmax of the scaled scores.
